// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg: shared system definitions for zeroHETI.
// Holds the system address map and the machine-timer register map types,
// plus a byte-enable merge helper used by register write paths.
package zeroheti_pkg;

    // Address window of one subordinate.
    typedef struct packed {
        logic [31:0] base;
        logic [31:0] last;
    } addr_rule_t;

    // System address map. Only the windows used in this slice are listed.
    typedef struct packed {
        addr_rule_t mtimer;
    } addr_map_t;

    localparam addr_map_t AddrMap = '{
        mtimer: '{base: 32'h0000_2100, last: 32'h0000_2113}
    };

    // Machine timer register map, as word index (offset[4:2]).
    localparam int unsigned MtimerNumRegs = 5;

    typedef enum logic [2:0] {
        MTIMER_MTIME_LO    = 3'd0,
        MTIMER_MTIME_HI    = 3'd1,
        MTIMER_MTIMECMP_LO = 3'd2,
        MTIMER_MTIMECMP_HI = 3'd3,
        MTIMER_CTRL        = 3'd4
    } mtimer_reg_e;

    // Widest supported prescaler field; narrower instances keep the upper bits at 0.
    localparam int unsigned MtimerMaxPrescW = 16;

    typedef struct packed {
        logic [MtimerMaxPrescW-1:0] presc;
        logic                       en;
    } mtimer_ctrl_t;

    // Replace the bytes of old_v selected by be with the matching bytes of new_v.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/zeroheti_mtimer_presc.sv
// zeroheti_mtimer_presc: prescaler for the machine timer.
// Counts cycles while enabled and strobes tick_o for one cycle each time the
// count reaches presc_i, so mtime advances once every presc_i+1 cycles.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_i           count enable; when low the counter is held at 0
//   clr_i          synchronous clear (any CTRL write)
//   presc_i        terminal count
//   tick_o         single-cycle increment strobe for mtime
module zeroheti_mtimer_presc
    import zeroheti_pkg::*;
#(
    parameter int unsigned PrescW = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [PrescW-1:0] presc_i,
    output logic              tick_o
);

    logic [PrescW-1:0] tick_cnt_d;
    logic [PrescW-1:0] tick_cnt_q;
    logic              tick_s;

    // The strobe is taken from the current count so presc=0 ticks every enabled cycle.
    assign tick_s = en_i && (tick_cnt_q == presc_i);
    assign tick_o = tick_s;

    // Next count: clear on CTRL write or disable, wrap on terminal count, else advance.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clr_i || !en_i) begin
            tick_cnt_d = {PrescW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_d = {PrescW{1'b0}};
        end else begin
            tick_cnt_d = tick_cnt_q + {{(PrescW-1){1'b0}}, 1'b1};
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_q <= {PrescW{1'b0}};
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/zeroheti_mtimer.sv
// zeroheti_mtimer: RISC-V machine timer, OBI subordinate.
// Holds the 64-bit mtime counter, 64-bit mtimecmp, CTRL (en, presc), the
// high-word read shadow and the registered timer interrupt.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_i/gnt_o                OBI request/grant (grant is req_i, no back-pressure)
//   addr_i, we_i, be_i, wdata_i OBI address phase
//   rvalid_o, rdata_o, err_o   OBI response phase, one cycle after grant
//   timer_irq_o                level interrupt, mtime >= mtimecmp
module zeroheti_mtimer
    import zeroheti_pkg::*;
#(
    parameter logic [31:0] BaseAddr = zeroheti_pkg::AddrMap.mtimer.base,
    parameter int unsigned PrescW   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        timer_irq_o
);

    localparam logic [MtimerMaxPrescW-1:0] PrescMask =
        MtimerMaxPrescW'((32'd1 << PrescW) - 32'd1);

    logic [63:0]  mtime_d,     mtime_q;
    logic [63:0]  mtimecmp_d,  mtimecmp_q;
    mtimer_ctrl_t ctrl_d,      ctrl_q;
    logic [31:0]  hi_shadow_d, hi_shadow_q;
    logic         rvalid_d,    rvalid_q;
    logic [31:0]  rdata_d,     rdata_q;
    logic         err_d,       err_q;
    logic         irq_d,       irq_q;

    logic [2:0]   reg_idx_s;
    logic [31:0]  ctrl_rd_s;
    logic [31:0]  ctrl_wr_s;
    logic         ctrl_clr_s;
    logic         tick_s;
    logic         addr_unused_s;

    // Base is word aligned, so offset[4:2] needs no borrow from the low bits.
    assign reg_idx_s     = addr_i[4:2] - BaseAddr[4:2];
    assign addr_unused_s = ^{addr_i[31:5], addr_i[1:0]};

    assign ctrl_rd_s = {8'd0, ctrl_q.presc, 7'd0, ctrl_q.en};
    assign ctrl_wr_s = be_merge(ctrl_rd_s, wdata_i, be_i);

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign timer_irq_o = irq_q;

    zeroheti_mtimer_presc #(
        .PrescW (PrescW)
    ) u_presc (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (ctrl_q.en),
        .clr_i   (ctrl_clr_s),
        .presc_i (ctrl_q.presc[PrescW-1:0]),
        .tick_o  (tick_s)
    );

    // Register file next state, bus decode and response data.
    always_comb begin
        mtime_d     = tick_s ? (mtime_q + 64'd1) : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        ctrl_d      = ctrl_q;
        hi_shadow_d = hi_shadow_q;
        rvalid_d    = 1'b0;
        rdata_d     = 32'd0;
        err_d       = 1'b0;
        ctrl_clr_s  = 1'b0;
        if (req_i) begin
            rvalid_d = 1'b1;
            if (we_i) begin
                case (reg_idx_s)
                    // A software write replaces the increment; the other half keeps its old value.
                    MTIMER_MTIME_LO:    mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], wdata_i, be_i)};
                    MTIMER_MTIME_HI:    mtime_d = {be_merge(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
                    MTIMER_MTIMECMP_LO: mtimecmp_d[31:0]  = be_merge(mtimecmp_q[31:0], wdata_i, be_i);
                    MTIMER_MTIMECMP_HI: mtimecmp_d[63:32] = be_merge(mtimecmp_q[63:32], wdata_i, be_i);
                    MTIMER_CTRL: begin
                        ctrl_d.en    = ctrl_wr_s[0];
                        ctrl_d.presc = ctrl_wr_s[8 +: MtimerMaxPrescW] & PrescMask;
                        ctrl_clr_s   = 1'b1;
                    end
                    default:            err_d = 1'b1;
                endcase
            end else begin
                case (reg_idx_s)
                    // Snapshot the high word so a following HI read pairs with this LO.
                    MTIMER_MTIME_LO: begin
                        rdata_d     = mtime_q[31:0];
                        hi_shadow_d = mtime_q[63:32];
                    end
                    MTIMER_MTIME_HI:    rdata_d = hi_shadow_q;
                    MTIMER_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                    MTIMER_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                    MTIMER_CTRL:        rdata_d = ctrl_rd_s;
                    default:            err_d   = 1'b1;
                endcase
            end
        end else begin
            rvalid_d = 1'b0;
        end
    end

    // Comparator on current register values; registered below.
    always_comb begin
        irq_d = (mtime_q >= mtimecmp_q);
    end

    // Timer state, shadow, OBI response and interrupt registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= {64{1'b1}};
            ctrl_q      <= '0;
            hi_shadow_q <= 32'd0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            ctrl_q      <= ctrl_d;
            hi_shadow_q <= hi_shadow_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_zeroheti_mtimer.sv
// Self-checking bench for zeroheti_mtimer: a register vector table after
// reset, then directed sequences for counting, wrap, collision, interrupt
// timing and reset during a transfer.
module tb_zeroheti_mtimer;

    localparam logic [31:0] BASE = 32'h0000_2100;
    localparam logic [31:0] O_LO = 32'h00, O_HI = 32'h04, O_CLO = 32'h08, O_CHI = 32'h0C, O_CTRL = 32'h10;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i = 32'd0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] wdata_i = 32'd0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        timer_irq_o;

    int checks = 0;
    int errors = 0;

    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    zeroheti_mtimer #(.BaseAddr(BASE), .PrescW(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .timer_irq_o (timer_irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] off;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle starting and ending at a falling edge; captures the response.
    task automatic bus(input logic we, input logic [31:0] off, input logic [3:0] be, input logic [31:0] wd);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = BASE + off;
        be_i    = be;
        wdata_i = wd;
        @(posedge clk);
        @(negedge clk);
        req_i     = 1'b0;
        rsp_valid = rvalid_o;
        rsp_data  = rdata_o;
        rsp_err   = err_o;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] wd);
        bus(1'b1, off, 4'hF, wd);
    endtask

    task automatic rd(input logic [31:0] off);
        bus(1'b0, off, 4'hF, 32'd0);
    endtask

    task automatic idle();
        req_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //            we    off     be     wdata          exp_rdata      err
        vecs[0]  = '{1'b0, O_LO,   4'hF, 32'h0,         32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, O_HI,   4'hF, 32'h0,         32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, O_CLO,  4'hF, 32'h0,         32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{1'b0, O_CHI,  4'hF, 32'h0,         32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{1'b0, O_CTRL, 4'hF, 32'h0,         32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, O_CTRL, 4'h2, 32'h0000_0501, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, O_CTRL, 4'hF, 32'h0,         32'h0000_0500, 1'b0};
        vecs[7]  = '{1'b1, O_CTRL, 4'hF, 32'h0,         32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 32'h18, 4'hF, 32'h0,         32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, O_CLO,  4'h5, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, O_CLO,  4'hF, 32'h0,         32'hFF34_FF78, 1'b0};
        vecs[12] = '{1'b1, O_CLO,  4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, O_CTRL, 4'hF, 32'h0,         32'h0000_0000, 1'b0};
        vecs[14] = '{1'b1, O_CTRL, 4'hF, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, O_CTRL, 4'hF, 32'h0,         32'h0000_FF00, 1'b0};
        vecs[16] = '{1'b1, O_CTRL, 4'hF, 32'h0,         32'h0000_0000, 1'b0};

        // Reset state of the outputs
        repeat (3) @(negedge clk);
        check32("rst_gnt",    {31'd0, gnt_o},       32'd0);
        check32("rst_rvalid", {31'd0, rvalid_o},    32'd0);
        check32("rst_rdata",  rdata_o,              32'd0);
        check32("rst_err",    {31'd0, err_o},       32'd0);
        check32("rst_irq",    {31'd0, timer_irq_o}, 32'd0);
        rst_ni = 1'b1;
        idle();

        // Register table: reset values, byte enables, error window
        for (int i = 0; i < 17; i++) begin
            bus(vecs[i].we, vecs[i].off, vecs[i].be, vecs[i].wdata);
            check32($sformatf("vec%0d_rvalid", i), {31'd0, rsp_valid}, 32'd1);
            check32($sformatf("vec%0d_rdata", i),  rsp_data, vecs[i].exp_rdata);
            check32($sformatf("vec%0d_err", i),    {31'd0, rsp_err}, {31'd0, vecs[i].exp_err});
            check32($sformatf("vec%0d_irq", i),    {31'd0, timer_irq_o}, 32'd0);
        end
        idle();
        check32("idle_rvalid", {31'd0, rvalid_o}, 32'd0);

        // Grant is combinational with the request
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = BASE + 32'h18;
        #1;
        check32("gnt_comb", {31'd0, gnt_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        check32("err_rvalid", {31'd0, rvalid_o}, 32'd1);
        check32("err_flag",   {31'd0, err_o},    32'd1);
        check32("err_rdata",  rdata_o,           32'd0);

        // Prescaler 3: mtime advances every 4 cycles
        wr(O_CTRL, 32'h0000_0301);
        repeat (40) idle();
        rd(O_LO);
        checks++;
        if (rsp_data < 32'd9 || rsp_data > 32'd11) begin
            errors++;
            $display("FAIL presc_count actual=%0d required=10+-1", rsp_data);
        end
        // Disable: mtime frozen
        wr(O_CTRL, 32'h0);
        rd(O_LO);
        check32("freeze_a", rsp_data, 32'd10);
        repeat (20) idle();
        rd(O_LO);
        check32("freeze_b", rsp_data, 32'd10);

        // Wrap across the 32-bit carry with LO/HI pairs
        wr(O_HI, 32'h0);
        wr(O_LO, 32'hFFFF_FFFE);
        wr(O_CTRL, 32'h1);
        idle();
        rd(O_LO);
        check32("wrap_lo0", rsp_data, 32'hFFFF_FFFF);
        rd(O_HI);
        check32("wrap_hi0", rsp_data, 32'h0);
        rd(O_LO);
        check32("wrap_lo1", rsp_data, 32'h1);
        rd(O_HI);
        check32("wrap_hi1", rsp_data, 32'h1);

        // Write beats increment in the same cycle
        wr(O_LO, 32'h100);
        rd(O_LO);
        check32("collide", rsp_data, 32'h100);

        // Interrupt at mtime == 50
        wr(O_CTRL, 32'h0);
        wr(O_LO, 32'h0);
        wr(O_HI, 32'h0);
        wr(O_CHI, 32'h0);
        wr(O_CLO, 32'd50);
        wr(O_CTRL, 32'h1);
        for (int i = 1; i <= 55; i++) begin
            idle();
            check32($sformatf("irq_c%0d", i), {31'd0, timer_irq_o}, (i >= 51) ? 32'd1 : 32'd0);
        end
        wr(O_CLO, 32'hFFFF_FFFF);
        check32("irq_wr_edge", {31'd0, timer_irq_o}, 32'd1);
        idle();
        check32("irq_drop", {31'd0, timer_irq_o}, 32'd0);

        // Reset while a response is outstanding
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = BASE + O_CLO;
        @(posedge clk);
        #1;
        check32("mid_rvalid_pre", {31'd0, rvalid_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check32("mid_rvalid_rst", {31'd0, rvalid_o}, 32'd0);
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        idle();
        check32("mid_rvalid_post", {31'd0, rvalid_o}, 32'd0);
        rd(O_LO);
        check32("mid_mtime", rsp_data, 32'd0);
        rd(O_CLO);
        check32("mid_cmp", rsp_data, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zeroheti_mtimer.md
# zeroheti_mtimer

RISC-V machine timer peripheral for zeroHETI, mapped at the `mtimer` window of the system address map (0x2100–0x2113, five word registers). It keeps a 64-bit `mtime` counter with a programmable prescaler and a 64-bit `mtimecmp`, and drives the level-sensitive machine timer interrupt into the interrupt controller. It is an OBI subordinate behind the system crossbar and sits directly downstream of the address-map decode.

## Interface
- `BaseAddr`, default `zeroheti_pkg::AddrMap.mtimer.base` (32'h2100): window base. Only bits [4:2] of the offset are decoded.
- `PrescW`, default 8: prescaler field width, 1..16.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low. One clock domain only.
- `req_i`  in  1  OBI request.
- `gnt_o`  out  1  OBI grant.
- `addr_i`  in  32  byte address, word aligned.
- `we_i`  in  1  write enable.
- `be_i`  in  4  byte enables.
- `wdata_i`  in  32  write data.
- `rvalid_o`  out  1  response valid.
- `rdata_o`  out  32  read data.
- `err_o`  out  1  response error.
- `timer_irq_o`  out  1  machine timer interrupt, level.

## Operation
- Register offsets: 0x00 `MTIME_LO`, 0x04 `MTIME_HI`, 0x08 `MTIMECMP_LO`, 0x0C `MTIMECMP_HI`, 0x10 `CTRL`. `CTRL[0]` is `en`, `CTRL[8+:PrescW]` is `presc`, other bits read 0 and ignore writes.
- Writes honour `be_i` per byte. Reads ignore `be_i`.
- Offsets 0x14–0x1C decode as an error: a write has no effect, and a read returns 0 with `err_o`=1.
- Prescaler:
  - An internal `PrescW`-bit `tick_cnt` runs while `en`=1.
  - When `tick_cnt == presc`, `tick_cnt` goes to 0 and `mtime` increments by 1. Otherwise `tick_cnt` increments.
  - With `presc`=0, `mtime` increments every cycle.
  - When `en`=0, `tick_cnt` is held at 0 and `mtime` is frozen.
  - Any write to `CTRL` clears `tick_cnt`.
- `mtime` wraps from 2^64−1 to 0 with no flag.
- A software write to `MTIME_LO` or `MTIME_HI` wins over the increment in the same cycle: only the written half is updated, and no increment happens that cycle.
- Read coherence:
  - Reading `MTIME_LO` returns the live low word and snapshots the live high word into `hi_shadow`.
  - Reading `MTIME_HI` returns `hi_shadow`.
  - So a LO-then-HI pair is atomic. `hi_shadow` resets to 0.
- Interrupt: `timer_irq_o` is registered and equals (`mtime` >= `mtimecmp`, unsigned 64-bit) evaluated on the previous cycle's register values.

## Timing
- Reset values:
  - `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `timer_irq_o`=0.
  - `mtime`=0, `mtimecmp`=all ones, `CTRL`=0, `tick_cnt`=0.
- Grant: `gnt_o` = `req_i`, combinational. There is no back-pressure, and back-to-back transfers are accepted every cycle.
- Response:
  - `rvalid_o` rises exactly one cycle after each accepted request.
  - `rdata_o` and `err_o` are valid only while `rvalid_o`=1. `rdata_o`=0 for writes.
- Write effect: register state updates on the grant edge.
  - A read in the next accepted cycle sees the new value.
  - `timer_irq_o` reflects a new `mtimecmp` or `mtime` one cycle after the write edge.
- Interrupt edge: when `mtime` becomes equal to `mtimecmp` at edge N, `timer_irq_o` rises at edge N+1.
- Reset mid-transfer: an outstanding response is dropped, and `rvalid_o` stays 0 after reset deasserts.

## Structure
- Add to `zeroheti_pkg`:
  - `mtimer_reg_e` (offset enum)
  - `mtimer_ctrl_t` (packed `en` / `presc`)
  - `MtimerNumRegs` = 5
- One sub-module, `zeroheti_mtimer_presc`, containing `tick_cnt`, the enable and the clear; it emits a single-cycle `tick` strobe.
- The top holds the registers, the OBI response pipeline, the shadow register and the comparator.

## Test plan
- Reset check: read all five registers; expect 0, 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, and `timer_irq_o`=0.
- Counting with prescaler:
  - Write `CTRL`=0x0301 (`presc`=3, `en`=1), wait 40 cycles, then read `MTIME_LO`; expect 10 ±1.
  - Write `CTRL`=0; `MTIME_LO` must then stay constant over 20 cycles.
- Interrupt:
  - Write `MTIMECMP_HI`=0 then `MTIMECMP_LO`=50, with `CTRL`=1.
  - `timer_irq_o` rises exactly one cycle after `mtime`=50.
  - Writing `MTIMECMP_LO`=0xFFFFFFFF drops it one cycle after the write.
- Wrap and atomic read:
  - Write `MTIME_HI`=0, `MTIME_LO`=0xFFFFFFFE, `CTRL`=1.
  - Issue back-to-back reads of LO then HI across the carry; expect a consistent pair (0xFFFFFFFF, 0) or (0x00000001, 1), never mixed.
- Write-vs-increment collision: with `presc`=0 and `en`=1, write `MTIME_LO`=0x100; read it on the next cycle; expect 0x100 (not 0x101).
- Byte enables and error response:
  - Write `CTRL` with `be_i`=4'b0010 and `wdata_i`=0x0000_0501; expect `CTRL`=0x0500.
  - Read offset 0x18; expect `rdata_o`=0 and `err_o`=1 with `rvalid_o` one cycle after `gnt_o`.
